// File: rtl/universal_shiftreg_burst.sv
// WIDTH-bit universal shift register with an autonomous burst engine that
// repeats one shift/rotate/load step COUNT times under a start/busy/done handshake.
module universal_shiftreg_burst #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             SIN,
  input  logic             start,
  input  logic [CNTW-1:0]  COUNT,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] M_LOAD = 3'b011;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [CNTW-1:0]  start_rem;

  function automatic logic [WIDTH-1:0] step_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic             s,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      3'b001:  r = {s, d[WIDTH-1:1]};
      3'b010:  r = {d[WIDTH-2:0], s};
      3'b011:  r = din;
      3'b100:  r = {d[0], d[WIDTH-1:1]};
      3'b101:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      3'b110:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // A burst load is a single step no matter what COUNT says.
  assign start_rem = (MODE == M_LOAD) ? CNTW'(1) : COUNT;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = MODE;
          rem_d  = start_rem;
          if (start_rem != '0) state_d = RUN;
          else done_d = 1'b1;
        end else begin
          data_d = step_f(MODE, data_q, SIN, DATAIN);
        end
      end
      RUN: begin
        data_d = step_f(mode_q, data_q, SIN, DATAIN);
        rem_d  = rem_q - CNTW'(1);
        if (rem_q == CNTW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign DATAOUT = data_q;
  assign SOUT_R  = data_q[0];
  assign SOUT_L  = data_q[WIDTH-1];
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_universal_shiftreg_burst.sv
// Scoreboard bench: stimulus queues expected post-edge state, a negedge
// monitor pops and compares against the DUT.
module tb_universal_shiftreg_burst;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] MODE = '0;
  logic [7:0] DATAIN = '0;
  logic       SIN = 1'b0;
  logic       start = 1'b0;
  logic [3:0] COUNT = '0;
  logic [7:0] DATAOUT;
  logic       SOUT_R, SOUT_L, busy, done;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  universal_shiftreg_burst #(.WIDTH(8), .CNTW(4)) dut (
    .clock(clock), .reset(reset), .MODE(MODE), .DATAIN(DATAIN),
    .SIN(SIN), .start(start), .COUNT(COUNT), .DATAOUT(DATAOUT),
    .SOUT_R(SOUT_R), .SOUT_L(SOUT_L), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("dataout", DATAOUT, e.d);
      chk("busy", {7'd0, busy}, {7'd0, e.b});
      chk("done", {7'd0, done}, {7'd0, e.dn});
      chk("sout_r", {7'd0, SOUT_R}, {7'd0, e.d[0]});
      chk("sout_l", {7'd0, SOUT_L}, {7'd0, e.d[7]});
    end
  end

  task automatic cyc(input logic [7:0] d, input logic b, input logic dn);
    exp_t e;
    e.d = d;
    e.b = b;
    e.dn = dn;
    q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic drv(input logic [2:0] m, input logic s,
                     input logic [7:0] din, input logic st,
                     input logic [3:0] c);
    MODE = m;
    SIN = s;
    DATAIN = din;
    start = st;
    COUNT = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  logic [7:0] asr15 [15];

  initial begin
    asr15 = '{8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    chk("rst_data", DATAOUT, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);

    // direct mode
    drv(3'b011, 0, 8'hA5, 0, 0); cyc(8'hA5, 0, 0);
    drv(3'b001, 1, 8'h00, 0, 0); cyc(8'hD2, 0, 0);
    drv(3'b010, 0, 8'h00, 0, 0); cyc(8'hA4, 0, 0);
    drv(3'b111, 1, 8'hFF, 0, 0); cyc(8'hA4, 0, 0);

    // rotate-left burst, MODE toggled and start retried mid-run
    drv(3'b011, 0, 8'h81, 0, 0); cyc(8'h81, 0, 0);
    drv(3'b101, 0, 8'h00, 1, 3); cyc(8'h81, 1, 0);
    drv(3'b001, 1, 8'h00, 0, 0); cyc(8'h03, 1, 0);
    drv(3'b010, 1, 8'h00, 1, 5); cyc(8'h06, 1, 0);
    drv(3'b000, 0, 8'h00, 0, 0); cyc(8'h0C, 0, 1);
    cyc(8'h0C, 0, 0);
    cyc(8'h0C, 0, 0);

    // arithmetic-right burst, then a start in the done cycle
    drv(3'b011, 0, 8'h90, 0, 0); cyc(8'h90, 0, 0);
    drv(3'b110, 0, 8'h00, 1, 2); cyc(8'h90, 1, 0);
    drv(3'b000, 0, 8'h00, 0, 0); cyc(8'hC8, 1, 0);
    cyc(8'hE4, 0, 1);
    drv(3'b110, 0, 8'h00, 1, 15); cyc(8'hE4, 1, 0);
    drv(3'b000, 0, 8'h00, 0, 0);
    for (int i = 0; i < 15; i++)
      cyc(asr15[i], (i < 14), (i == 14));
    cyc(8'hFF, 0, 0);

    // COUNT=0 burst
    drv(3'b011, 0, 8'h3C, 0, 0); cyc(8'h3C, 0, 0);
    drv(3'b001, 1, 8'h00, 1, 0); cyc(8'h3C, 0, 1);
    drv(3'b000, 0, 8'h00, 0, 0); cyc(8'h3C, 0, 0);

    // burst load ignores COUNT, DATAIN sampled at the step
    drv(3'b011, 0, 8'h77, 1, 9); cyc(8'h3C, 1, 0);
    drv(3'b000, 0, 8'h5A, 0, 0); cyc(8'h5A, 0, 1);
    cyc(8'h5A, 0, 0);

    // logical right burst longer than WIDTH fills with SIN
    drv(3'b001, 1, 8'h00, 1, 10); cyc(8'h5A, 1, 0);
    drv(3'b000, 1, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(8'hFF << (8 - (i < 8 ? i + 1 : 8)) | (8'h5A >> (i + 1)),
          (i < 9), (i == 9));
    cyc(8'hFF, 0, 0);

    // asynchronous reset mid-burst
    drv(3'b100, 0, 8'h00, 1, 6); cyc(8'hFF, 1, 0);
    drv(3'b000, 0, 8'h00, 0, 0); cyc(8'hFF, 1, 0);
    reset = 1'b1;
    #1;
    chk("arst_data", DATAOUT, 8'h00);
    chk("arst_busy", {7'd0, busy}, 8'h00);
    chk("arst_done", {7'd0, done}, 8'h00);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);

    @(negedge clock);
    #1;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shiftreg_burst.md
# universal_shiftreg_burst

Parametrised universal shift register with an autonomous multi-step burst engine. It keeps the single-cycle hold/shift/load behaviour of the team's 4-bit universal shift register and generalises it to WIDTH bits. It adds serial in/out, rotate and arithmetic-shift modes, and a start/busy/done handshake that applies one operation COUNT times without per-cycle control. It sits in datapath blocks that need serialisation, barrel-style alignment, or multi-bit shifts under simple control.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- CNTW, 4: width of the COUNT input; a burst performs 0 to 2^CNTW-1 steps.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- MODE  in  3  operation select (see Operation).
- DATAIN  in  WIDTH  parallel load data.
- SIN  in  1  serial input bit for logical shifts.
- start  in  1  burst request; sampled only in IDLE.
- COUNT  in  CNTW  number of burst steps; sampled together with start.
- DATAOUT  out  WIDTH  register contents.
- SOUT_R  out  1  DATAOUT[0], combinational from the register.
- SOUT_L  out  1  DATAOUT[WIDTH-1], combinational from the register.
- busy  out  1  high while a burst is running.
- done  out  1  one-cycle pulse after a burst completes.

## Operation
- Step function f(MODE), applied to the register contents (not to DATAIN):
  - 000: hold.
  - 001: logical shift right, {SIN, D[W-1:1]}.
  - 010: logical shift left, {D[W-2:0], SIN}.
  - 011: parallel load, DATAIN.
  - 100: rotate right, {D[0], D[W-1:1]}.
  - 101: rotate left, {D[W-2:0], D[W-1]}.
  - 110: arithmetic shift right, {D[W-1], D[W-1:1]}.
  - 111: reserved; behaves as hold.
- FSM states: IDLE and RUN.
- IDLE with start=0 (direct mode): f(MODE) applies at every clock edge, using live MODE, SIN and DATAIN.
- IDLE with start=1:
  - DATAOUT is not modified at that edge.
  - MODE is latched into mode_q.
  - remaining is set to COUNT; if MODE=011, remaining is set to 1 regardless of COUNT.
  - If remaining is nonzero, the FSM goes to RUN.
  - If COUNT=0 (and MODE≠011), the FSM stays in IDLE and done pulses.
- RUN:
  - Each edge applies f(mode_q) and decrements remaining.
  - SIN and DATAIN are sampled live at each step.
  - MODE and start are ignored.
  - At the edge where remaining goes 1 to 0, the FSM returns to IDLE and done is set for one cycle.
- done is high in the cycle immediately after the completing edge. That cycle is IDLE, so direct-mode operation and a new start are both accepted in it.
- A start while busy is ignored; it is neither queued nor does it restart the burst.
- COUNT ≥ WIDTH is legal:
  - Logical shifts fill entirely with SIN values.
  - Arithmetic shift right saturates to all copies of the sign bit.
  - Rotates wrap naturally (modulo WIDTH).

## Timing
- Reset values: DATAOUT=0, busy=0, done=0, state=IDLE, remaining=0, mode_q=000.
- Assertion of reset takes effect asynchronously, without waiting for a clock edge.
- Release of reset is synchronous to clock; the first active edge is the one after deassertion.
- Reset mid-burst aborts the burst: no done pulse, busy drops immediately.
- Direct mode latency: 1 edge.
- Burst timing, with start accepted at edge 0 and COUNT=N>0:
  - busy is high from after edge 0 through after edge N-1.
  - Steps occur at edges 1..N.
  - busy=0 and done=1 after edge N.
  - done clears after edge N+1.
- COUNT=0: done=1 after edge 0; busy never rises.
- SOUT_L and SOUT_R change only when DATAOUT changes.

## Test plan
- Assert reset asynchronously between edges with DATAOUT=0xFF and a burst running → DATAOUT=0x00, busy=0, done=0 before the next edge; no done pulse afterwards.
- Direct mode (WIDTH=8): MODE=011, DATAIN=0xA5 → 0xA5; then MODE=001, SIN=1 → 0xD2; then MODE=010, SIN=0 → 0xA4; MODE=111 → 0xA4 held.
- Burst rotate left: DATAOUT=0x81, start=1, MODE=101, COUNT=3 → busy high for 3 cycles, DATAOUT 0x03, 0x06, 0x0C, done pulses once after the third step; toggling MODE during RUN has no effect.
- Burst arithmetic right: DATAOUT=0x90, MODE=110, COUNT=2 → 0xC8 then 0xE4, done pulses; same with COUNT=15 → 0xFF.
- Boundaries:
  - start with COUNT=0 from 0x3C → done after 1 edge, busy stays 0, DATAOUT=0x3C.
  - start asserted during RUN → ignored, no extra steps.
  - start during the done cycle → accepted, new burst begins.
- Burst load: MODE=011, COUNT=9, DATAIN=0x5A → single step, DATAOUT=0x5A, busy for 1 cycle, done pulses.
